buffer_write_arbiter: RTL

Credit-aware round-robin arbiter that shares the single write port of the dual-clock credit buffer between NUM_REQ producers in the write-clock domain. It grants whole bursts to one producer at a time and registers the winning beat onto re_valid/data_in. It never issues a beat the buffer's re_credit cannot cover, including the beat still in flight. It also keeps CREDIT_RESERVE slots back as a CDC safety margin.

---
 rtl/buffer_write_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/buffer_write_arbiter.sv
// buffer_write_arbiter: credit-aware round-robin burst arbiter feeding the write port of a dual-clock credit buffer
module buffer_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 16,
    parameter int MAX_BURST      = 8,
    parameter int CREDIT_RESERVE = 0
) (
    input  logic                         re_clk,
    input  logic                         re_reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [$clog2(DEPTH):0]       re_credit,
    output logic                         re_valid,
    output logic [WIDTH-1:0]             data_in,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [15:0]                  stall_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [CW:0] RESV = (CW+1)'(CREDIT_RESERVE);
    localparam logic [8:0] MAXB = 9'(MAX_BURST);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    ptr_q, ptr_d, grant_q, grant_d, pick, idx, next_ptr;
    logic [7:0]       beat_q, beat_d;
    logic             re_valid_q, re_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      stall_q, stall_d;
    logic [CW:0]      need;
    logic             credit_ok, g_valid, g_last, accept, burst_done;

    // the registered beat is the only one the buffer has not yet charged against re_credit
    assign need       = (CW+1)'(re_valid_q) + RESV;
    assign credit_ok  = {1'b0, re_credit} > need;
    assign g_valid    = req_valid[grant_q];
    assign g_last     = req_last[grant_q];
    assign accept     = (state_q == BURST) && g_valid && credit_ok;
    assign burst_done = accept && (g_last || ({1'b0, beat_q} + 9'd1 == MAXB));
    assign next_ptr   = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) pick = idx;
        end
    end

    always_comb begin
        req_ready = '0;
        if (!re_reset && state_q == BURST && credit_ok) req_ready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        stall_d    = stall_q;
        re_valid_d = accept;
        data_d     = accept ? req_data[grant_q*WIDTH +: WIDTH] : data_q;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                grant_d = pick;
                beat_d  = '0;
                state_d = BURST;
            end
        end else if (state_q == BURST) begin
            if (accept) beat_d = beat_q + 8'd1;
            if (burst_done || !g_valid) begin
                state_d = IDLE;
                ptr_d   = next_ptr;
            end else if (!credit_ok) begin
                state_d = STALL;
            end
        end else if (state_q == STALL) begin
            stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
            if (credit_ok) state_d = BURST;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge re_clk) begin
        if (re_reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            beat_q     <= '0;
            re_valid_q <= 1'b0;
            data_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            re_valid_q <= re_valid_d;
            data_q     <= data_d;
            stall_q    <= stall_d;
        end
    end

    assign re_valid  = re_valid_q;
    assign data_in   = data_q;
    assign grant_id  = grant_q;
    assign busy      = state_q != IDLE;
    assign stall_cnt = stall_q;
endmodule
